// File: rtl/i2c_master_controller.sv
// I2C bus initiator: one fixed-length transaction per accepted Start.
// Generates START, {address, R/W}, NBYTES data bytes with ACK handling and
// STOP on an open-drain SCL/SDA pair. All bus outputs are registered.
module i2c_master_controller #(
    parameter int ADDRESSLENGTH = 7,
    parameter int NBYTES        = 2,
    parameter int CLKDIV        = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     RorW,
    input  logic [ADDRESSLENGTH-1:0] SlaveAddress,
    input  logic [8*NBYTES-1:0]      WriteData,
    output logic [8*NBYTES-1:0]      ReadData,
    output logic                     Busy,
    output logic                     Done,
    output logic                     AckError,
    output logic                     Scl,
    output logic                     SdaOe,
    input  logic                     SdaIn
);

    // One bit-time is four quarters of CLKDIV clocks each.
    localparam int BIT_CLKS  = 4 * CLKDIV;
    localparam int CW        = $clog2(BIT_CLKS);
    // Shift register wide enough for the address phase or a data byte.
    localparam int TXW       = (ADDRESSLENGTH + 1 > 8) ? ADDRESSLENGTH + 1 : 8;
    localparam int BITW      = $clog2(TXW);
    localparam int BYW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CW-1:0]   CNT_LAST      = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0]   CNT_SAMPLE    = CW'(3 * CLKDIV - 1);
    localparam logic [CW-1:0]   Q1_START      = CW'(CLKDIV);
    localparam logic [CW-1:0]   Q2_START      = CW'(2 * CLKDIV);
    localparam logic [CW-1:0]   Q3_START      = CW'(3 * CLKDIV);
    localparam logic [BITW-1:0] ADDR_LAST_BIT = BITW'(ADDRESSLENGTH);
    localparam logic [BITW-1:0] DATA_LAST_BIT = BITW'(7);
    localparam logic [BYW-1:0]  LAST_BYTE     = BYW'(NBYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RACK,
        S_STOP
    } state_t;

    // Control registers (reset)
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BITW-1:0]     bit_q, bit_d;
    logic [BYW-1:0]      byte_q, byte_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ackerr_q, ackerr_d;
    logic                scl_q, scl_d;
    logic                sdaoe_q, sdaoe_d;
    logic [8*NBYTES-1:0] rdata_q, rdata_d;

    // Datapath registers (no reset)
    logic                     rw_q, rw_d;
    logic [ADDRESSLENGTH-1:0] addr_q, addr_d;
    logic [8*NBYTES-1:0]      wdata_q, wdata_d;
    logic [TXW-1:0]           tx_q, tx_d;
    logic [7:0]               rx_q, rx_d;
    logic                     samp_q, samp_d;

    logic bit_end;
    logic sample_now;

    // Select byte idx of a packed multi-byte word.
    function automatic logic [7:0] get_byte(input logic [8*NBYTES-1:0] data,
                                            input logic [BYW-1:0] idx);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == BYW'(k)) b = data[8*k +: 8];
        end
        return b;
    endfunction

    // Replace byte idx of a packed multi-byte word.
    function automatic logic [8*NBYTES-1:0] put_byte(input logic [8*NBYTES-1:0] data,
                                                     input logic [BYW-1:0] idx,
                                                     input logic [7:0] b);
        logic [8*NBYTES-1:0] r;
        r = data;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == BYW'(k)) r[8*k +: 8] = b;
        end
        return r;
    endfunction

    // Left-align a data byte in the transmit shifter so the MSB goes out first.
    function automatic logic [TXW-1:0] align_byte(input logic [7:0] b);
        return TXW'(b) << (TXW - 8);
    endfunction

    assign bit_end    = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
    assign sample_now = (state_q != S_IDLE) && (cnt_q == CNT_SAMPLE);

    // Next-state logic for the sequencer, plus output decode from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ackerr_d = ackerr_q;
        rdata_d  = rdata_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        samp_d   = samp_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        if (sample_now) begin
            samp_d = SdaIn;
        end

        case (state_q)
            S_IDLE: begin
                // A Start coinciding with the Done pulse is deliberately dropped.
                if (Start && !done_q) begin
                    state_d  = S_START;
                    // The accept cycle is the first clock of the START bit-time.
                    cnt_d    = CW'(1);
                    bit_d    = '0;
                    byte_d   = '0;
                    busy_d   = 1'b1;
                    ackerr_d = 1'b0;
                    rw_d     = RorW;
                    addr_d   = SlaveAddress;
                    wdata_d  = WriteData;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_ADDR;
                    bit_d   = '0;
                    // Wire R/W bit is 0 for a write, so invert RorW.
                    tx_d    = TXW'({addr_q, ~rw_q}) << (TXW - (ADDRESSLENGTH + 1));
                end
            end
            S_ADDR: begin
                if (bit_end) begin
                    tx_d = tx_q << 1;
                    if (bit_q == ADDR_LAST_BIT) state_d = S_ADDR_ACK;
                    else                        bit_d   = bit_q + 1'b1;
                end
            end
            S_ADDR_ACK: begin
                if (bit_end) begin
                    bit_d  = '0;
                    byte_d = '0;
                    if (samp_q) begin
                        ackerr_d = 1'b1;
                        state_d  = S_STOP;
                    end else if (rw_q) begin
                        state_d = S_WDATA;
                        tx_d    = align_byte(get_byte(wdata_q, '0));
                    end else begin
                        state_d = S_RDATA;
                    end
                end
            end
            S_WDATA: begin
                if (bit_end) begin
                    tx_d = tx_q << 1;
                    if (bit_q == DATA_LAST_BIT) state_d = S_WACK;
                    else                        bit_d   = bit_q + 1'b1;
                end
            end
            S_WACK: begin
                if (bit_end) begin
                    if (samp_q) begin
                        ackerr_d = 1'b1;
                        state_d  = S_STOP;
                    end else if (byte_q == LAST_BYTE) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_WDATA;
                        byte_d  = byte_q + 1'b1;
                        bit_d   = '0;
                        tx_d    = align_byte(get_byte(wdata_q, byte_q + 1'b1));
                    end
                end
            end
            S_RDATA: begin
                if (sample_now) begin
                    rx_d = {rx_q[6:0], SdaIn};
                end
                if (bit_end) begin
                    if (bit_q == DATA_LAST_BIT) begin
                        state_d = S_RACK;
                        rdata_d = put_byte(rdata_q, byte_q, rx_q);
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_RACK: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_RDATA;
                        byte_d  = byte_q + 1'b1;
                        bit_d   = '0;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Bus pins follow the state being entered so they line up with it.
        scl_d   = 1'b1;
        sdaoe_d = 1'b0;
        case (state_d)
            S_START: begin
                sdaoe_d = (cnt_d >= Q2_START);
            end
            S_ADDR, S_WDATA: begin
                scl_d   = (cnt_d >= Q2_START);
                sdaoe_d = ~tx_d[TXW-1];
            end
            S_ADDR_ACK, S_WACK, S_RDATA: begin
                scl_d = (cnt_d >= Q2_START);
            end
            S_RACK: begin
                // ACK every byte but the last, which is NACKed to end the read.
                scl_d   = (cnt_d >= Q2_START);
                sdaoe_d = (byte_d != LAST_BYTE);
            end
            S_STOP: begin
                scl_d   = (cnt_d >= Q1_START);
                sdaoe_d = (cnt_d < Q3_START);
            end
            default: begin
                scl_d   = 1'b1;
                sdaoe_d = 1'b0;
            end
        endcase
    end

    // Control state and registered bus/status outputs; reset releases both lines
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ackerr_q <= 1'b0;
            scl_q    <= 1'b1;
            sdaoe_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ackerr_q <= ackerr_d;
            scl_q    <= scl_d;
            sdaoe_q  <= sdaoe_d;
            rdata_q  <= rdata_d;
        end
    end

    // Latched request, shifters and sampled SDA
    always_ff @(posedge Clock) begin
        rw_q    <= rw_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        tx_q    <= tx_d;
        rx_q    <= rx_d;
        samp_q  <= samp_d;
    end

    assign ReadData = rdata_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign AckError = ackerr_q;
    assign Scl      = scl_q;
    assign SdaOe    = sdaoe_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: a bit-time level model of the expected bus
// waveform drives a per-cycle compare, and a simple slave answers on SDA.
module tb_i2c_master_controller;

    localparam int AL  = 7;
    localparam int NB  = 2;
    localparam int CD  = 4;
    localparam int BIT = 4 * CD;

    localparam int K_START = 0;
    localparam int K_MST   = 1;   // master drives mval on SDA
    localparam int K_REL   = 2;   // master releases SDA
    localparam int K_STOP  = 3;

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic            Start = 1'b0;
    logic            RorW  = 1'b0;
    logic [AL-1:0]   SlaveAddress = '0;
    logic [8*NB-1:0] WriteData = '0;
    logic [8*NB-1:0] ReadData;
    logic            Busy, Done, AckError, Scl, SdaOe;
    logic            SdaIn;
    logic            slave_low = 1'b0;

    // Open-drain line: low if either side pulls it down.
    assign SdaIn = ~(SdaOe | slave_low);

    i2c_master_controller #(.ADDRESSLENGTH(AL), .NBYTES(NB), .CLKDIV(CD)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .RorW(RorW),
        .SlaveAddress(SlaveAddress), .WriteData(WriteData), .ReadData(ReadData),
        .Busy(Busy), .Done(Done), .AckError(AckError), .Scl(Scl), .SdaOe(SdaOe),
        .SdaIn(SdaIn)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Transaction plan: one entry per bit-time.
    int         nbits;
    int         kind [64];
    logic       mval [64];
    logic       slow [64];
    int         done_cyc;
    int         ack_cyc;
    int         rack_cyc [NB];
    logic [15:0] rd_new;
    logic [15:0] rd_prev = '0;
    logic       capq [$];

    task automatic check(input string name, input int t, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
        end
    endtask

    task automatic add_bit(input int k, input logic v, input logic s);
        kind[nbits] = k;
        mval[nbits] = v;
        slow[nbits] = s;
        nbits++;
    endtask

    // Build the bit-time sequence of a transaction from its description.
    task automatic build_plan(input logic rw, input logic [AL-1:0] addr,
                              input logic [15:0] wd, input logic [15:0] rd,
                              input logic addr_nack, input int nack_byte);
        logic [7:0] ab;
        logic [7:0] b;
        logic       stopped;
        nbits   = 0;
        ack_cyc = 1 << 30;
        for (int k = 0; k < NB; k++) rack_cyc[k] = 1 << 30;
        rd_new  = rd;
        stopped = 1'b0;
        add_bit(K_START, 1'b0, 1'b0);
        ab = {addr, ~rw};
        for (int i = 7; i >= 0; i--) add_bit(K_MST, ab[i], 1'b0);
        add_bit(K_REL, 1'b0, ~addr_nack);
        if (addr_nack) begin
            ack_cyc = BIT * nbits;
        end else if (rw) begin
            for (int k = 0; k < NB; k++) begin
                if (!stopped) begin
                    b = wd[8*k +: 8];
                    for (int i = 7; i >= 0; i--) add_bit(K_MST, b[i], 1'b0);
                    add_bit(K_REL, 1'b0, (k != nack_byte));
                    if (k == nack_byte) begin
                        ack_cyc = BIT * nbits;
                        stopped = 1'b1;
                    end
                end
            end
        end else begin
            for (int k = 0; k < NB; k++) begin
                b = rd[8*k +: 8];
                for (int i = 7; i >= 0; i--) add_bit(K_REL, 1'b0, ~b[i]);
                rack_cyc[k] = BIT * nbits;
                add_bit(K_MST, (k == NB - 1), 1'b0);
            end
        end
        add_bit(K_STOP, 1'b0, 1'b0);
        done_cyc = BIT * nbits;
    endtask

    // Expected {Busy, Done, Scl, SdaOe, AckError} at cycle t after accept.
    function automatic logic [4:0] exp_ctl(input int t);
        int   c;
        int   q;
        logic busy, done, scl, oe;
        busy = 1'b0; done = 1'b0; scl = 1'b1; oe = 1'b0;
        if (t < done_cyc) begin
            c = t % BIT;
            q = c / CD;
            busy = 1'b1;
            case (kind[t / BIT])
                K_START: oe = (q >= 2);
                K_MST: begin scl = (q >= 2); oe = ~mval[t / BIT]; end
                K_REL: scl = (q >= 2);
                default: begin scl = (q >= 1); oe = (q < 3); end
            endcase
        end else if (t == done_cyc) begin
            done = 1'b1;
        end
        return {busy, done, scl, oe, (t >= ack_cyc)};
    endfunction

    function automatic logic [15:0] exp_rd(input int t);
        logic [15:0] r;
        r = rd_prev;
        for (int k = 0; k < NB; k++) begin
            if (t >= rack_cyc[k]) r[8*k +: 8] = rd_new[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic cap_bit(input int i);
        if (i < capq.size()) return capq[i];
        return 1'bx;
    endfunction

    function automatic logic [7:0] cap_byte(input int off);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = cap_bit(off + i);
        return b;
    endfunction

    // One per-cycle compare of the control pins and ReadData at cycle t.
    task automatic compare_cycle(input int t);
        check("ctl", t, 32'({Busy, Done, Scl, SdaOe, AckError}), 32'(exp_ctl(t)));
        check("rdata", t, 32'(ReadData), 32'(exp_rd(t)));
    endtask

    task automatic issue_start(input logic rw, input logic [AL-1:0] addr,
                               input logic [15:0] wd);
        @(negedge Clock);
        RorW = rw; SlaveAddress = addr; WriteData = wd; Start = 1'b1;
        @(posedge Clock);
        #1;
        // Scramble the request inputs to show they were latched.
        Start = 1'b0; RorW = ~rw; SlaveAddress = ~addr; WriteData = ~wd;
    endtask

    task automatic run_txn(input logic rw, input logic [AL-1:0] addr,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input logic addr_nack, input int nack_byte,
                           input logic poke, output int obs_done);
        logic prev_scl;
        build_plan(rw, addr, wd, rd, addr_nack, nack_byte);
        capq.delete();
        obs_done = -1;
        prev_scl = 1'b1;
        issue_start(rw, addr, wd);
        for (int t = 1; t <= done_cyc + 1; t++) begin
            @(negedge Clock);
            if (Scl && !prev_scl) capq.push_back(SdaIn);
            prev_scl = Scl;
            if (Done && obs_done < 0) obs_done = t;
            compare_cycle(t);
            slave_low = (t < done_cyc) ? slow[t / BIT] : 1'b0;
            if (poke) Start = (t == 100) || (t == done_cyc);
        end
        rd_prev = exp_rd(done_cyc);
    endtask

    task automatic reset_mid_addr();
        build_plan(1'b1, 7'h07, 16'hF555, 16'h0000, 1'b0, -1);
        issue_start(1'b1, 7'h07, 16'hF555);
        // Cycle 70 lies in bit-time 4, which is address bit 3.
        for (int t = 1; t <= 70; t++) begin
            @(negedge Clock);
            compare_cycle(t);
            slave_low = slow[t / BIT];
        end
        check("mid_kind", 70, 32'(kind[70 / BIT]), 32'(K_MST));
        Reset = 1'b0;
        slave_low = 1'b0;
        rd_prev = '0;
        @(posedge Clock);
        #1;
        check("mid_rst_scl", 0, 32'(Scl), 32'd1);
        check("mid_rst_sdaoe", 0, 32'(SdaOe), 32'd0);
        check("mid_rst_busy", 0, 32'(Busy), 32'd0);
        check("mid_rst_done", 0, 32'(Done), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            check("mid_quiet", i, 32'({Busy, Done, Scl, SdaOe, AckError}), 32'b00100);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int od;
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_scl", 0, 32'(Scl), 32'd1);
        check("rst_sdaoe", 0, 32'(SdaOe), 32'd0);
        check("rst_busy", 0, 32'(Busy), 32'd0);
        check("rst_done", 0, 32'(Done), 32'd0);
        check("rst_ackerr", 0, 32'(AckError), 32'd0);
        check("rst_rdata", 0, 32'(ReadData), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Write 16'hF555 to 7'h07, all bytes ACKed.
        run_txn(1'b1, 7'h07, 16'hF555, 16'h0000, 1'b0, -1, 1'b0, od);
        check("w_model_done", 0, 32'(done_cyc), 32'd464);
        check("w_done", 0, 32'(od), 32'd464);
        check("w_addr", 0, 32'(cap_byte(0)), 32'h0E);
        check("w_byte0", 0, 32'(cap_byte(9)), 32'h55);
        check("w_byte1", 0, 32'(cap_byte(18)), 32'hF5);
        check("w_rises", 0, 32'(capq.size()), 32'd28);
        check("w_ackerr", 0, 32'(AckError), 32'd0);

        // Read from 7'h07; slave returns 8'h55 then 8'hF5.
        run_txn(1'b0, 7'h07, 16'h0000, 16'hF555, 1'b0, -1, 1'b0, od);
        check("r_done", 0, 32'(od), 32'd464);
        check("r_addr", 0, 32'(cap_byte(0)), 32'h0F);
        check("r_byte0", 0, 32'(cap_byte(9)), 32'h55);
        check("r_mack", 0, 32'(cap_bit(17)), 32'd0);
        check("r_byte1", 0, 32'(cap_byte(18)), 32'hF5);
        check("r_mnack", 0, 32'(cap_bit(26)), 32'd1);
        check("r_rdata", 0, 32'(ReadData), 32'hF555);

        // Address NACK.
        run_txn(1'b1, 7'h17, 16'hA5C3, 16'h0000, 1'b1, -1, 1'b0, od);
        check("an_model_done", 0, 32'(done_cyc), 32'd176);
        check("an_done", 0, 32'(od), 32'd176);
        check("an_addr", 0, 32'(cap_byte(0)), 32'h2E);
        check("an_nack", 0, 32'(cap_bit(8)), 32'd1);
        check("an_ackerr", 0, 32'(AckError), 32'd1);
        check("an_rdata", 0, 32'(ReadData), 32'hF555);

        // Write with NACK on byte 0; the new Start must clear AckError.
        run_txn(1'b1, 7'h07, 16'hF555, 16'h0000, 1'b0, 0, 1'b0, od);
        check("wn_model_done", 0, 32'(done_cyc), 32'd320);
        check("wn_done", 0, 32'(od), 32'd320);
        check("wn_rises", 0, 32'(capq.size()), 32'd19);
        check("wn_ackerr", 0, 32'(AckError), 32'd1);

        // Start pulsed while busy and in the Done cycle.
        run_txn(1'b1, 7'h07, 16'hF555, 16'h0000, 1'b0, -1, 1'b1, od);
        check("pk_done", 0, 32'(od), 32'd464);
        check("pk_ackerr", 0, 32'(AckError), 32'd0);
        check("pk_idle", 0, 32'(Busy), 32'd0);

        // Reset in the middle of the address byte, then a clean write.
        reset_mid_addr();
        run_txn(1'b1, 7'h07, 16'hF555, 16'h0000, 1'b0, -1, 1'b0, od);
        check("ar_done", 0, 32'(od), 32'd464);
        check("ar_byte1", 0, 32'(cap_byte(18)), 32'hF5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
